// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Instruction fetch stage placed directly in front of the ICache. It owns the
// architectural fetch PC, issues one fetch request at a time, applies static
// next-PC prediction to every returned instruction and buffers the results in
// a small in-order queue that the decoder drains with a valid/ready handshake.
// A clear from the ROB empties the queue and redirects fetch.
//
// Parameters
//   IQ_DEPTH  instruction queue entries (power of 2, >= 2)
//   RESET_PC  fetch PC loaded at reset
//
// Ports
//   clk_in              system clock
//   rst_in              asynchronous active-low reset
//   rdy_in              global ready; when low every register holds
//   rob_clear_up        flush/redirect request from the ROB
//   rob_new_pc          redirect target, valid with rob_clear_up
//   icache_pc           fetch address presented to the ICache
//   icache_start_fetch  fetch request to the ICache
//   icache_hit          ICache returns an instruction this cycle
//   icache_inst         returned instruction word
//   icache_inst_addr    address of the returned instruction
//   dec_ready           decoder can accept one instruction
//   if_valid            queue head is valid
//   if_inst             queue head instruction
//   if_pc               queue head PC
//   if_pred_taken       queue head was predicted taken
//   if_pred_pc          predicted next PC for the queue head
// ---------------------------------------------------------------------------
module inst_fetcher #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] rob_new_pc,
  output logic [31:0] icache_pc,
  output logic        icache_start_fetch,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  input  logic [31:0] icache_inst_addr,
  input  logic        dec_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_pc
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(IQ_DEPTH);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              start_req;
  logic [31:0]       pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic [31:0]       q_inst     [IQ_DEPTH];
  logic [31:0]       q_pc       [IQ_DEPTH];
  logic              q_taken    [IQ_DEPTH];
  logic [31:0]       q_pred_pc  [IQ_DEPTH];

  logic              accept;
  logic              pop_fire;
  logic              pred_taken;
  logic [31:0]       pred_pc;
  logic [31:0]       imm_j;
  logic [31:0]       imm_b;

  // Static prediction on the word coming back from the ICache. JAL targets
  // are always taken; conditional branches are taken only when the offset is
  // negative (sign bit set), the classic backward-taken/forward-not-taken
  // heuristic. Everything else, JALR included, falls through to pc+4.
  always_comb begin
    imm_j      = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                  icache_inst[30:21], 1'b0};
    imm_b      = {{20{icache_inst[31]}}, icache_inst[7], icache_inst[30:25],
                  icache_inst[11:8], 1'b0};
    pred_taken = 1'b0;
    pred_pc    = pc + 32'd4;
    if (icache_inst[6:0] == OPC_JAL) begin
      pred_taken = 1'b1;
      pred_pc    = pc + imm_j;
    end else if (icache_inst[6:0] == OPC_BRANCH && icache_inst[31]) begin
      pred_taken = 1'b1;
      pred_pc    = pc + imm_b;
    end
  end

  // start_req is the registered image of "state == FETCH"; gating acceptance
  // with it guarantees a hit is only taken while a request is on the bus.
  // A clear wins over both push and pop, so neither fires in that cycle.
  always_comb begin
    accept   = rdy_in && !rob_clear_up && start_req && icache_hit &&
               (icache_inst_addr == pc);
    pop_fire = rdy_in && !rob_clear_up && if_valid && dec_ready;
  end

  // Occupancy after this cycle; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (accept && !pop_fire) begin
      count_next = count + 1'b1;
    end else if (!accept && pop_fire) begin
      count_next = count - 1'b1;
    end
  end

  // Next-state logic. Filling the last slot parks the fetcher in STALL until
  // the decoder frees an entry; FLUSH is a single dead cycle after a clear.
  always_comb begin
    state_next = state;
    if (rob_clear_up) begin
      state_next = FLUSH;
    end else begin
      case (state)
        FETCH: begin
          if (accept && count_next == FULL_COUNT) begin
            state_next = STALL;
          end
        end
        STALL: begin
          if (count_next < FULL_COUNT) begin
            state_next = FETCH;
          end
        end
        FLUSH: begin
          state_next = FETCH;
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  // All architectural state. Nothing moves while rdy_in is low. The request
  // strobe is registered from the next state so it stays glitch-free and is
  // low throughout reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= FETCH;
      start_req <= 1'b0;
      pc        <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_inst[i]    <= '0;
        q_pc[i]      <= '0;
        q_taken[i]   <= 1'b0;
        q_pred_pc[i] <= '0;
      end
    end else if (rdy_in) begin
      state     <= state_next;
      start_req <= (state_next == FETCH);
      if (rob_clear_up) begin
        pc    <= rob_new_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        count <= count_next;
        if (pop_fire) begin
          head <= head + 1'b1;
        end
        if (accept) begin
          q_inst[tail]    <= icache_inst;
          q_pc[tail]      <= pc;
          q_taken[tail]   <= pred_taken;
          q_pred_pc[tail] <= pred_pc;
          tail            <= tail + 1'b1;
          pc              <= pred_pc;
        end
      end
    end
  end

  // ICache request side.
  assign icache_pc          = pc;
  assign icache_start_fetch = start_req;

  // Decoder side: the queue head is presented directly.
  assign if_valid      = (count != '0);
  assign if_inst       = q_inst[head];
  assign if_pc         = q_pc[head];
  assign if_pred_taken = q_taken[head];
  assign if_pred_pc    = q_pred_pc[head];

endmodule

// File: tb/tb_inst_fetcher.sv
// ---------------------------------------------------------------------------
// tb_inst_fetcher
//
// Self-checking bench for inst_fetcher. A behavioural model (a queue of
// fetched entries, the fetch PC and two flags) tracks what the fetcher must
// present; one compare process checks every output against it on each falling
// edge. Directed scenarios with literal expectations run first, followed by a
// long randomized phase that includes redirects, freezes and mid-run resets.
// ---------------------------------------------------------------------------
module tb_inst_fetcher;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] icache_pc;
  logic        start_fetch;
  logic        hit = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] inst_addr = '0;
  logic        dec_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred_pc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc      = RST_PC;
  logic        m_flush   = 1'b0;
  logic        m_started = 1'b0;

  inst_fetcher #(
    .IQ_DEPTH (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_n),
    .rdy_in             (rdy),
    .rob_clear_up       (clear),
    .rob_new_pc         (new_pc),
    .icache_pc          (icache_pc),
    .icache_start_fetch (start_fetch),
    .icache_hit         (hit),
    .icache_inst        (inst),
    .icache_inst_addr   (inst_addr),
    .dec_ready          (dec_ready),
    .if_valid           (if_valid),
    .if_inst            (if_inst),
    .if_pc              (if_pc),
    .if_pred_taken      (if_pred_taken),
    .if_pred_pc         (if_pred_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after a falling edge, then waits for the
  // next falling edge so the caller can inspect the result of that cycle.
  task automatic applyStimulus(input logic rst_v, input logic rdy_v,
                               input logic hit_v, input logic [31:0] inst_v,
                               input logic [31:0] addr_v, input logic dr_v,
                               input logic clr_v, input logic [31:0] npc_v);
    #1;
    rst_n     = rst_v;
    rdy       = rdy_v;
    hit       = hit_v;
    inst      = inst_v;
    inst_addr = addr_v;
    dec_ready = dr_v;
    clear     = clr_v;
    new_pc    = npc_v;
    @(negedge clk);
  endtask

  // Prediction straight from the instruction-set rules, using signed integer
  // offsets assembled field by field.
  function automatic entry_t predict(input logic [31:0] w, input logic [31:0] at);
    entry_t e;
    int     off;
    e.inst    = w;
    e.pc      = at;
    e.taken   = 1'b0;
    e.pred_pc = at + 32'd4;
    if (w[6:0] == 7'b1101111) begin
      off = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 +
            int'(w[30:21]) * 2;
      e.taken   = 1'b1;
      e.pred_pc = at + 32'(off);
    end else if (w[6:0] == 7'b1100011 && w[31]) begin
      off = -4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      e.taken   = 1'b1;
      e.pred_pc = at + 32'(off);
    end
    return e;
  endfunction

  // A request is expected whenever the fetcher has been running for at least
  // one cycle, is not in the dead cycle after a redirect, and has room.
  function automatic logic exp_start();
    return m_started && !m_flush && (m_q.size() < DEPTH);
  endfunction

  // Reference model update on each rising edge, plus immediate clearing when
  // reset is asserted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc      = RST_PC;
      m_flush   = 1'b0;
      m_started = 1'b0;
    end else if (rdy) begin
      if (clear) begin
        m_q.delete();
        m_pc    = new_pc;
        m_flush = 1'b1;
      end else begin
        logic   take;
        entry_t e;
        take = exp_start() && hit && (inst_addr == m_pc);
        if (m_q.size() > 0 && dec_ready) begin
          void'(m_q.pop_front());
        end
        if (take) begin
          e = predict(inst, m_pc);
          m_q.push_back(e);
          m_pc = e.pred_pc;
        end
        m_flush = 1'b0;
      end
      m_started = 1'b1;
    end
  end

  // The single compare process: every falling edge, all outputs against the
  // model (reset values while reset is held, the head entry while valid).
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_start_fetch", 32'(start_fetch), 32'd0);
      checkOutput("rst_icache_pc", icache_pc, RST_PC);
      checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
      checkOutput("rst_if_inst", if_inst, 32'd0);
      checkOutput("rst_if_pc", if_pc, 32'd0);
      checkOutput("rst_if_pred_taken", 32'(if_pred_taken), 32'd0);
      checkOutput("rst_if_pred_pc", if_pred_pc, 32'd0);
    end else begin
      checkOutput("model_start_fetch", 32'(start_fetch), 32'(exp_start()));
      checkOutput("model_icache_pc", icache_pc, m_pc);
      checkOutput("model_if_valid", 32'(if_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        checkOutput("model_if_inst", if_inst, m_q[0].inst);
        checkOutput("model_if_pc", if_pc, m_q[0].pc);
        checkOutput("model_if_pred_taken", 32'(if_pred_taken), 32'(m_q[0].taken));
        checkOutput("model_if_pred_pc", if_pred_pc, m_q[0].pred_pc);
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       r = {r[31:7], 7'b1101111};
      1:       r = {r[31:7], 7'b1100011};
      2:       r = {r[31:7], 7'b1100111};
      3:       r = 32'h00000013;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Directed scenarios first, then the randomized phase.
  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_start_fetch", 32'(start_fetch), 32'd0);
    checkOutput("reset_icache_pc", icache_pc, 32'h0);
    checkOutput("reset_if_valid", 32'(if_valid), 32'd0);

    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("first_start_fetch", 32'(start_fetch), 32'd1);
    checkOutput("first_icache_pc", icache_pc, 32'h0);

    applyStimulus(1, 1, 1, 32'h00000013, 32'h0, 0, 0, 32'h0);
    checkOutput("nop_if_valid", 32'(if_valid), 32'd1);
    checkOutput("nop_if_pc", if_pc, 32'h0);
    checkOutput("nop_if_inst", if_inst, 32'h00000013);
    checkOutput("nop_pred_taken", 32'(if_pred_taken), 32'd0);
    checkOutput("nop_pred_pc", if_pred_pc, 32'h4);
    checkOutput("nop_icache_pc", icache_pc, 32'h4);

    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 1, 32'h100);
    checkOutput("redirect_if_valid", 32'(if_valid), 32'd0);
    checkOutput("redirect_start_fetch", 32'(start_fetch), 32'd0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("redirect_refetch", 32'(start_fetch), 32'd1);
    checkOutput("redirect_icache_pc", icache_pc, 32'h100);

    applyStimulus(1, 1, 1, 32'h0100006F, 32'h100, 0, 0, 32'h0);
    checkOutput("jal_icache_pc", icache_pc, 32'h110);
    checkOutput("jal_if_pc", if_pc, 32'h100);
    checkOutput("jal_pred_taken", 32'(if_pred_taken), 32'd1);
    checkOutput("jal_pred_pc", if_pred_pc, 32'h110);

    applyStimulus(1, 1, 1, 32'hFE000EE3, 32'h110, 1, 0, 32'h0);
    checkOutput("beq_if_pc", if_pc, 32'h110);
    checkOutput("beq_if_inst", if_inst, 32'hFE000EE3);
    checkOutput("beq_pred_taken", 32'(if_pred_taken), 32'd1);
    checkOutput("beq_pred_pc", if_pred_pc, 32'h10C);
    checkOutput("beq_icache_pc", icache_pc, 32'h10C);

    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 1, 32'h00000013, 32'(4 * k), 0, 0, 32'h0);
    end
    checkOutput("full_start_fetch", 32'(start_fetch), 32'd0);
    checkOutput("full_if_pc", if_pc, 32'h0);
    checkOutput("full_icache_pc", icache_pc, 32'h10);
    applyStimulus(1, 1, 1, 32'h00000013, 32'h10, 0, 0, 32'h0);
    checkOutput("full_hit_ignored", 32'(start_fetch), 32'd0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    checkOutput("pop_from_full_if_pc", if_pc, 32'h4);
    checkOutput("pop_from_full_refetch", 32'(start_fetch), 32'd1);
    applyStimulus(1, 1, 1, 32'h00000013, 32'h10, 1, 0, 32'h0);
    checkOutput("push_pop_if_pc", if_pc, 32'h8);
    checkOutput("push_pop_icache_pc", icache_pc, 32'h14);

    applyStimulus(1, 1, 1, 32'h00000013, 32'h20, 0, 0, 32'h0);
    checkOutput("mismatch_icache_pc", icache_pc, 32'h14);
    checkOutput("mismatch_start_fetch", 32'(start_fetch), 32'd1);

    applyStimulus(1, 1, 1, 32'h00000013, 32'h14, 0, 1, 32'h200);
    checkOutput("clear_hit_if_valid", 32'(if_valid), 32'd0);
    checkOutput("clear_hit_start_fetch", 32'(start_fetch), 32'd0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("after_flush_start", 32'(start_fetch), 32'd1);
    checkOutput("after_flush_icache_pc", icache_pc, 32'h200);
    checkOutput("after_flush_if_valid", 32'(if_valid), 32'd0);
    applyStimulus(1, 1, 1, 32'h00000013, 32'h200, 0, 0, 32'h0);
    checkOutput("after_flush_if_pc", if_pc, 32'h200);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, 32'h00000013, 32'h204, 1, 0, 32'h0);
      checkOutput("frozen_if_pc", if_pc, 32'h200);
      checkOutput("frozen_icache_pc", icache_pc, 32'h204);
      checkOutput("frozen_if_valid", 32'(if_valid), 32'd1);
    end
    applyStimulus(1, 1, 1, 32'h00000013, 32'h204, 1, 0, 32'h0);
    checkOutput("resume_if_pc", if_pc, 32'h204);
    checkOutput("resume_icache_pc", icache_pc, 32'h208);

    for (int n = 0; n < 3000; n++) begin
      logic        r_rst;
      logic [31:0] r_addr;
      r_rst  = ($urandom_range(0, 399) != 0);
      r_addr = ($urandom_range(0, 4) == 0) ? (m_pc ^ (32'd4 << $urandom_range(0, 6))) : m_pc;
      applyStimulus(r_rst, ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
                    rand_inst(), r_addr, ($urandom_range(0, 4) < 3),
                    ($urandom_range(0, 39) == 0), $urandom & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
